// File: rtl/comp_persist_nbits_if.sv
// Sample/threshold/mode bus into one comparator channel and its filtered result back out.
// Driver side takes the master modport, the comparator takes the slave modport.
interface comp_persist_nbits_if #(
    parameter int WIDTH = 16
);
    logic             i_valid;
    logic [WIDTH-1:0] i_in;
    logic [WIDTH-1:0] i_ref;
    logic [1:0]       i_mode;
    logic             i_clr;
    logic             o_out;
    logic             o_valid;
    logic             o_trip;

    modport master (
        output i_valid, i_in, i_ref, i_mode, i_clr,
        input  o_out, o_valid, o_trip
    );

    modport slave (
        input  i_valid, i_in, i_ref, i_mode, i_clr,
        output o_out, o_valid, o_trip
    );
endinterface

// File: rtl/comp_persist_nbits.sv
// Unsigned compare with PERSIST-sample debounce on trip and release; outputs 1 clk after the deciding sample.
// No backpressure: every in_valid sample is taken. COMP_HYST_EN adds a HYST-LSB release margin for modes 00/01.
module comp_persist_nbits #(
    parameter int WIDTH   = 16,
    parameter int PERSIST = 4,
    parameter int HYST    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    comp_persist_nbits_if.slave  bus
);
    localparam int            CW        = $clog2(PERSIST + 1);
    localparam logic [CW:0]   PERSIST_C = (CW + 1)'(PERSIST);

    if (PERSIST < 1 || HYST < 0) begin : g_param_check
        $error("comp_persist_nbits: PERSIST must be >= 1 and HYST >= 0");
    end

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_TRIPPED = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_mode_q;
    logic          r_out;
    logic          r_out_valid;
    logic          r_trip;

    logic          w_match;
    logic          w_release;
    logic          w_cond;
    logic          w_mode_chg;
    logic [CW:0]   w_cnt_nxt;

    always_comb begin
        case (bus.i_mode)
            2'b00:   w_match = bus.i_in >  bus.i_ref;
            2'b01:   w_match = bus.i_in <  bus.i_ref;
            2'b10:   w_match = bus.i_in == bus.i_ref;
            default: w_match = bus.i_in != bus.i_ref;
        endcase
    end

`ifdef COMP_HYST_EN
    localparam logic [WIDTH:0] HYST_C = (WIDTH + 1)'(HYST);

    logic [WIDTH:0] w_in_ext;
    logic [WIDTH:0] w_ref_ext;
    logic [WIDTH:0] w_ref_lo;
    logic [WIDTH:0] w_ref_hi;

    // One extra bit lets ref-HYST and ref+HYST saturate instead of wrapping.
    always_comb begin
        w_in_ext  = {1'b0, bus.i_in};
        w_ref_ext = {1'b0, bus.i_ref};
        w_ref_lo  = (w_ref_ext > HYST_C) ? (w_ref_ext - HYST_C) : '0;
        w_ref_hi  = w_ref_ext + HYST_C;
        if (w_ref_hi[WIDTH]) begin
            w_ref_hi = {1'b0, {WIDTH{1'b1}}};
        end
        case (bus.i_mode)
            2'b00:   w_release = w_in_ext <= w_ref_lo;
            2'b01:   w_release = w_in_ext >= w_ref_hi;
            default: w_release = !w_match;
        endcase
    end
`else
    always_comb w_release = !w_match;
`endif

    always_comb begin
        w_cond     = (r_state == ST_TRIPPED) ? w_release : w_match;
        w_mode_chg = bus.i_mode != r_mode_q;
        w_cnt_nxt  = w_cond ? ({1'b0, r_cnt} + 1'b1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mode_q    <= 2'b00;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_trip      <= 1'b0;
        end else if (bus.i_clr) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mode_q    <= 2'b00;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_trip      <= 1'b0;
        end else begin
            r_out_valid <= bus.i_valid;
            r_trip      <= 1'b0;
            if (bus.i_valid) begin
                r_mode_q <= bus.i_mode;
                // A new mode starts a fresh run at this sample without moving the state.
                if (w_mode_chg) begin
                    r_cnt <= CW'(w_cond);
                end else if (w_cnt_nxt >= PERSIST_C) begin
                    r_cnt <= '0;
                    if (r_state == ST_IDLE) begin
                        r_state <= ST_TRIPPED;
                        r_out   <= 1'b1;
                        r_trip  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_out   <= 1'b0;
                    end
                end else begin
                    r_cnt <= w_cnt_nxt[CW-1:0];
                end
            end
        end
    end

    assign bus.o_out   = r_out;
    assign bus.o_valid = r_out_valid;
    assign bus.o_trip  = r_trip;
endmodule

// File: tb/tb_comp_persist_nbits.sv
// Bench for comp_persist_nbits: directed vector table, hand-built corner sequences, then random traffic
// checked against a history-based reference model; follows COMP_HYST_EN when it is defined.
module tb_comp_persist_nbits;
    localparam int WIDTH   = 16;
    localparam int PERSIST = 4;
    localparam int HYST    = 8;
    localparam int MAXV    = 65535;

    logic clk;
    logic rst_n;

    comp_persist_nbits_if #(.WIDTH(WIDTH)) bus ();

    comp_persist_nbits #(
        .WIDTH   (WIDTH),
        .PERSIST (PERSIST),
        .HYST    (HYST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: remembers the agree/disagree history since the last state or mode change.
    bit m_tripped;
    bit m_out_valid;
    bit m_trip;
    int m_mode;
    bit m_hist[$];

    function automatic bit ref_match(int a, int b, int md);
        case (md)
            0:       return a > b;
            1:       return a < b;
            2:       return a == b;
            default: return a != b;
        endcase
    endfunction

    function automatic bit ref_release(int a, int b, int md);
`ifdef COMP_HYST_EN
        int lo;
        int hi;
        lo = (b - HYST < 0) ? 0 : b - HYST;
        hi = (b + HYST > MAXV) ? MAXV : b + HYST;
        if (md == 0) return a <= lo;
        if (md == 1) return a >= hi;
`endif
        return !ref_match(a, b, md);
    endfunction

    function automatic int trailing_agree();
        int run = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (!m_hist[i]) break;
            run++;
        end
        return run;
    endfunction

    task automatic model_reset();
        m_tripped   = 1'b0;
        m_out_valid = 1'b0;
        m_trip      = 1'b0;
        m_mode      = 0;
        m_hist.delete();
    endtask

    task automatic model_update(input int v, input int a, input int b, input int md, input int c);
        bit agree;
        m_trip      = 1'b0;
        m_out_valid = (v != 0) && (c == 0);
        if (c != 0) begin
            m_tripped = 1'b0;
            m_mode    = 0;
            m_hist.delete();
        end else if (v != 0) begin
            agree = m_tripped ? ref_release(a, b, md) : ref_match(a, b, md);
            if (md != m_mode) begin
                m_hist.delete();
                m_hist.push_back(agree);
                m_mode = md;
            end else begin
                m_hist.push_back(agree);
                if (trailing_agree() >= PERSIST) begin
                    if (!m_tripped) m_trip = 1'b1;
                    m_tripped = !m_tripped;
                    m_hist.delete();
                end
            end
        end
    endtask

    // Drive one cycle of inputs, let one rising edge take them, then settle 1 time unit.
    task automatic step(input int v, input int a, input int b, input int md, input int c);
        bus.i_valid = 1'(v);
        bus.i_in    = 16'(a);
        bus.i_ref   = 16'(b);
        bus.i_mode  = 2'(md);
        bus.i_clr   = 1'(c);
        @(posedge clk);
        model_update(v, a, b, md, c);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, m_mode, 0);
    endtask

    typedef struct {
        int v;
        int a;
        int b;
        int md;
        int c;
        bit eo;
        bit ev;
        bit et;
    } vec_t;

    function automatic vec_t mk(int v, int a, int b, int md, int c, int eo, int ev, int et);
        vec_t t;
        t.v  = v;
        t.a  = a;
        t.b  = b;
        t.md = md;
        t.c  = c;
        t.eo = 1'(eo);
        t.ev = 1'(ev);
        t.et = 1'(et);
        return t;
    endfunction

    vec_t tbl[15];
    int   ov_cnt;
    int   trip_cnt;
    int   rb;
    int   ra;
    int   rmd;

    initial begin
        // Four samples above ref trip; then a run broken by 999 needs a fresh four.
        tbl[0]  = mk(1, 1001, 1000, 0, 0, 0, 1, 0);
        tbl[1]  = mk(1, 1001, 1000, 0, 0, 0, 1, 0);
        tbl[2]  = mk(1, 1001, 1000, 0, 0, 0, 1, 0);
        tbl[3]  = mk(1, 1001, 1000, 0, 0, 1, 1, 1);
        tbl[4]  = mk(0, 1001, 1000, 0, 0, 1, 0, 0);
        tbl[5]  = mk(0, 1001, 1000, 0, 1, 0, 0, 0);
        tbl[6]  = mk(1, 1001, 1000, 0, 0, 0, 1, 0);
        tbl[7]  = mk(1, 1001, 1000, 0, 0, 0, 1, 0);
        tbl[8]  = mk(1, 1001, 1000, 0, 0, 0, 1, 0);
        tbl[9]  = mk(1,  999, 1000, 0, 0, 0, 1, 0);
        tbl[10] = mk(1, 1001, 1000, 0, 0, 0, 1, 0);
        tbl[11] = mk(1, 1001, 1000, 0, 0, 0, 1, 0);
        tbl[12] = mk(1, 1001, 1000, 0, 0, 0, 1, 0);
        tbl[13] = mk(1, 1001, 1000, 0, 0, 1, 1, 1);
        tbl[14] = mk(0, 1001, 1000, 0, 0, 1, 0, 0);

        bus.i_valid = 1'b0;
        bus.i_in    = '0;
        bus.i_ref   = '0;
        bus.i_mode  = 2'b00;
        bus.i_clr   = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", bus.o_out, 1'b0);
        chk("reset_out_valid", bus.o_valid, 1'b0);
        chk("reset_trip", bus.o_trip, 1'b0);
        rst_n = 1'b1;
        idle();

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].md, tbl[i].c);
            chk($sformatf("tbl%0d_out", i), bus.o_out, tbl[i].eo);
            chk($sformatf("tbl%0d_valid", i), bus.o_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_trip", i), bus.o_trip, tbl[i].et);
        end

        // Release from TRIPPED at 995 then 992 with ref 1000.
        for (int i = 0; i < 4; i++) begin
            step(1, 995, 1000, 0, 0);
`ifdef COMP_HYST_EN
            chk($sformatf("rel995_%0d_out", i), bus.o_out, 1'b1);
`else
            chk($sformatf("rel995_%0d_out", i), bus.o_out, i != 3);
`endif
            chk($sformatf("rel995_%0d_trip", i), bus.o_trip, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 992, 1000, 0, 0);
`ifdef COMP_HYST_EN
            chk($sformatf("rel992_%0d_out", i), bus.o_out, i != 3);
`else
            chk($sformatf("rel992_%0d_out", i), bus.o_out, 1'b0);
`endif
        end

        // Equality at all-ones trips; a mode switch counts as the first sample of the run.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, MAXV, MAXV, 2, 0);
            chk($sformatf("eq_ffff_%0d_out", i), bus.o_out, i == 3);
            chk($sformatf("eq_ffff_%0d_trip", i), bus.o_trip, i == 3);
        end
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(1, int'($urandom_range(0, MAXV)), 0, 1, 0);
            chk($sformatf("lt_zero_%0d_out", i), bus.o_out, 1'b0);
        end

        // Low ref: the release threshold saturates at zero under hysteresis.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 4, 3, 0, 0);
        chk("ref3_trip_out", bus.o_out, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 3, 0, 0);
`ifdef COMP_HYST_EN
            chk($sformatf("ref3_in1_%0d_out", i), bus.o_out, 1'b1);
`else
            chk($sformatf("ref3_in1_%0d_out", i), bus.o_out, i != 3);
`endif
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 3, 0, 0);
`ifdef COMP_HYST_EN
            chk($sformatf("ref3_in0_%0d_out", i), bus.o_out, i != 3);
`else
            chk($sformatf("ref3_in0_%0d_out", i), bus.o_out, 1'b0);
`endif
        end

        // Idle gaps between matching samples do not break the run.
        step(0, 0, 0, 0, 1);
        ov_cnt   = 0;
        trip_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step(1, 1001, 1000, 0, 0);
            ov_cnt   += int'(bus.o_valid);
            trip_cnt += int'(bus.o_trip);
            if (k < 3) chk($sformatf("gap_%0d_out", k), bus.o_out, 1'b0);
            for (int g = 0; g < 5; g++) begin
                step(0, 1001, 1000, 0, 0);
                ov_cnt   += int'(bus.o_valid);
                trip_cnt += int'(bus.o_trip);
            end
        end
        chk_int("gap_out_valid_count", ov_cnt, 4);
        chk_int("gap_trip_count", trip_cnt, 1);
        chk("gap_final_out", bus.o_out, 1'b1);

        // clr wins over a valid sample; async reset clears outputs without waiting for an edge.
        step(1, 1001, 1000, 0, 1);
        chk("clr_out", bus.o_out, 1'b0);
        chk("clr_trip", bus.o_trip, 1'b0);
        chk("clr_out_valid", bus.o_valid, 1'b0);
        for (int i = 0; i < 4; i++) step(1, 1001, 1000, 0, 0);
        chk("retrip_out", bus.o_out, 1'b1);
        chk("retrip_trip", bus.o_trip, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_out", bus.o_out, 1'b0);
        chk("rst_mid_out_valid", bus.o_valid, 1'b0);
        chk("rst_mid_trip", bus.o_trip, 1'b0);
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        chk("post_rst_out", bus.o_out, 1'b0);
        chk("post_rst_trip", bus.o_trip, 1'b0);
        chk("post_rst_out_valid", bus.o_valid, 1'b0);

        // Random traffic against the reference model.
        step(0, 0, 0, 0, 1);
        rmd = 0;
        rb  = 1000;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) rmd = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       rb = 0;
                    1:       rb = MAXV;
                    default: rb = int'($urandom_range(0, MAXV));
                endcase
            end
            ra = (rb + int'($urandom_range(0, 24)) - 12) & MAXV;
            if ($urandom_range(0, 5) == 0) ra = rb;
            step(($urandom_range(0, 3) != 0) ? 1 : 0, ra, rb, rmd,
                 ($urandom_range(0, 63) == 0) ? 1 : 0);
            chk($sformatf("rnd%0d_out", n), bus.o_out, m_tripped);
            chk($sformatf("rnd%0d_valid", n), bus.o_valid, m_out_valid);
            chk($sformatf("rnd%0d_trip", n), bus.o_trip, m_trip);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
